// File: rtl/weight_loader.sv
// Sequential weight-memory writer: packs four stream bytes (MSB first) into a
// 32-bit word, writes words to addresses 0..DEPTH-1, then reports done and a checksum.
module weight_loader #(
  parameter int unsigned DEPTH  = 50176,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  byte_cnt;
  logic [31:0] word;
  logic        hs;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; a handshake only exists while in LOAD
  always_comb begin
    state_nxt = state;
    hs        = 1'b0;
    case (state)
      IDLE, DONE: if (start) state_nxt = LOAD;
      LOAD: begin
        hs = byte_valid;
        if (byte_valid && byte_cnt == 2'd3) state_nxt = WRITE;
      end
      WRITE:   state_nxt = (wr_addr == LAST_ADDR) ? DONE : LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs registered from the next state so they align with the state register
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      byte_ready <= (state_nxt == LOAD);
      wr_en      <= (state_nxt == WRITE);
      busy       <= (state_nxt == LOAD) || (state_nxt == WRITE);
      done       <= (state_nxt == DONE);
    end
  end

  // Byte assembly, address counter and checksum
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt <= 2'd0;
      word     <= 32'd0;
      wr_addr  <= '0;
      wr_data  <= 32'd0;
      checksum <= 32'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            byte_cnt <= 2'd0;
            wr_addr  <= '0;
            checksum <= 32'd0;
          end
        end
        LOAD: begin
          if (hs) begin
            word     <= {word[23:0], byte_in};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) wr_data <= {word[23:0], byte_in};
          end
        end
        WRITE: begin
          checksum <= checksum + wr_data;
          if (wr_addr != LAST_ADDR) wr_addr <= wr_addr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// Directed + randomized bench for weight_loader (DEPTH=4) against a word-level
// reference: expected address = word index since start, checksum = 32-bit sum.
module tb_weight_loader;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        byte_in = 8'h00;
  logic              byte_valid = 1'b0;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              busy;
  logic              done;
  logic [31:0]       checksum;

  int n_chk  = 0;
  int n_fail = 0;
  int wr_cnt = 0;

  // reference model: words written since last start
  int unsigned exp_idx = 0;
  logic [31:0] exp_sum = 32'd0;

  weight_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (wr_en === 1'b1) wr_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_wr_en"},      32'(wr_en),      32'd0);
    chk({tag, "_busy"},       32'(busy),       32'd0);
    chk({tag, "_done"},       32'(done),       32'd0);
    chk({tag, "_wr_addr"},    32'(wr_addr),    32'd0);
    chk({tag, "_wr_data"},    wr_data,         32'd0);
    chk({tag, "_checksum"},   checksum,        32'd0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    repeat (n) begin
      byte_valid = 1'($urandom);
      start      = 1'($urandom);
      byte_in    = 8'($urandom);
      @(negedge clk);
    end
    reset = 1'b0;
    start = 1'b0;
    byte_valid = 1'b0;
    exp_idx = 0;
    exp_sum = 32'd0;
  endtask

  task automatic start_load(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_idx = 0;
    exp_sum = 32'd0;
    chk({tag, "_ready_after_start"}, 32'(byte_ready), 32'd1);
    chk({tag, "_busy_after_start"},  32'(busy),       32'd1);
    chk({tag, "_done_after_start"},  32'(done),       32'd0);
  endtask

  // returns just after the clock edge on which the byte was accepted
  task automatic send_byte(input logic [7:0] b, input bit stall);
    bit hs;
    hs = 1'b0;
    for (int t = 0; t < 64 && !hs; t++) begin
      @(negedge clk);
      byte_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      byte_in    = b;
      hs = byte_ready && byte_valid;
      @(posedge clk);
    end
    if (!hs) chk("handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic load_word(input logic [31:0] w, input bit stall, input bit poke_start,
                           input bit start_in_write);
    int unsigned last;
    for (int i = 0; i < 4; i++) begin
      if (poke_start && i == 2) begin
        @(negedge clk);
        byte_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      send_byte(8'(w >> (24 - 8 * i)), stall);
    end
    last = (exp_idx == DEPTH - 1) ? 1 : 0;
    @(negedge clk);
    byte_valid = 1'b1;
    byte_in    = 8'($urandom);
    start      = start_in_write;
    chk("write_wr_en",      32'(wr_en),      32'd1);
    chk("write_byte_ready", 32'(byte_ready), 32'd0);
    chk("write_addr",       32'(wr_addr),    32'(exp_idx));
    chk("write_data",       wr_data,         w);
    exp_sum = exp_sum + w;
    exp_idx++;
    @(negedge clk);
    byte_valid = 1'b0;
    start      = 1'b0;
    chk("after_write_wr_en", 32'(wr_en),    32'd0);
    chk("after_write_sum",   checksum,      exp_sum);
    chk("after_write_done",  32'(done),     32'(last));
    chk("after_write_busy",  32'(busy),     32'(last == 0));
    chk("after_write_ready", 32'(byte_ready), 32'(last == 0));
  endtask

  initial begin
    int snap;

    // reset with random input noise
    do_reset(2);
    chk_idle_outputs("reset");

    // single word, back-to-back bytes
    start_load("single");
    snap = wr_cnt;
    load_word(32'h12345678, 1'b0, 1'b0, 1'b0);
    chk("single_one_pulse", 32'(wr_cnt - snap), 32'd1);
    chk("single_checksum",  checksum, 32'h12345678);

    // full load with stalls; checksum wraps to zero; start during last write ignored
    do_reset(1);
    start_load("full");
    load_word(32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    load_word(32'h00000002, 1'b1, 1'b0, 1'b0);
    load_word(32'h80000000, 1'b1, 1'b0, 1'b0);
    load_word(32'h7FFFFFFF, 1'b1, 1'b0, 1'b1);
    chk("full_checksum_wrap", checksum, 32'h00000000);
    repeat (2) @(negedge clk);
    chk("full_done_held", 32'(done), 32'd1);

    // start in the middle of a word is ignored
    do_reset(1);
    start_load("poke");
    load_word($urandom, 1'b0, 1'b1, 1'b0);
    load_word($urandom, 1'b1, 1'b0, 1'b0);

    // reset after three bytes discards the partial word
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0);
    snap = wr_cnt;
    do_reset(1);
    chk_idle_outputs("midreset");
    repeat (3) @(negedge clk);
    chk("midreset_no_write", 32'(wr_cnt - snap), 32'd0);
    start_load("after_reset");
    load_word(32'hAABBCCDD, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < DEPTH; i++) load_word($urandom, 1'b1, 1'b0, 1'b0);

    // reload from DONE restarts at address 0 with a fresh checksum
    chk("reload_pre_done", 32'(done), 32'd1);
    start_load("reload");
    load_word(32'h00000001, 1'b0, 1'b0, 1'b0);
    chk("reload_checksum", checksum, 32'h00000001);
    for (int i = 1; i < DEPTH; i++) load_word($urandom, 1'b1, 1'b0, 1'b0);
    chk("reload_done", 32'(done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
